krake_port_rx: RTL and testbench

Wishbone-style 8-bit register slave that receives asynchronous serial bytes (8N1, LSB first) on rx_i and buffers them in a small FIFO for the bus master. It is the receive-side counterpart of the krake TX port and sits on the same krake port bus. It uses the same register map constants and the same single-strobe, registered-ack handshake. Status flags report data available, FIFO full, overrun and framing error.

---
 rtl/krake_port_rx_pkg.sv | 28 ++
 rtl/krake_port_rx_uart_rx.sv | 102 ++++++++++
 rtl/krake_port_rx.sv | 151 +++++++++++++++
 tb/tb_krake_port_rx.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/krake_port_rx_pkg.sv
// Shared definitions for the krake port bus receive slave.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
// Holds the register map and STATUS bit positions, which match the TX side,
// plus the receiver state encoding.
package krake_port_rx_pkg;

  // Register map, common to every slave on the krake port bus.
  localparam logic [3:0] UART_STATUS  = 4'h0;
  localparam logic [3:0] UART_DATAREG = 4'h1;

  // STATUS bit positions. FLUSH is write-only. Bits 6:4 carry the FIFO count on reads.
  localparam int RXST_AVAIL = 0;
  localparam int RXST_FULL  = 1;
  localparam int RXST_OVR   = 2;
  localparam int RXST_FERR  = 3;
  localparam int RXST_FLUSH = 4;
  localparam int RXST_BUSY  = 7;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_BREAK
  } rx_state_e;

endpackage

// File: rtl/krake_port_rx_uart_rx.sv
// 8N1 serial receiver: synchronizer, baud counter, shift register and framing FSM.
// Latency: push/frame_err_pulse are asserted in the cycle that ends at the stop-bit sample edge.
// Backpressure: none; push is a one-cycle strobe and the consumer must take it or drop it.
// Ports: clk, rst_n (async active-low); rx (raw serial input);
//        rx_sync (synchronized line), busy (state != IDLE),
//        push + data[7:0] (good byte), frame_err_pulse (stop bit sampled low).
module krake_port_rx_uart_rx
  import krake_port_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic       rx_sync,
  output logic       busy,
  output logic       push,
  output logic [7:0] data,
  output logic       frame_err_pulse
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);

  logic            rx_meta;
  rx_state_e       state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [2:0]      bit_idx, bit_nxt;
  logic [7:0]      shift, shift_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      state   <= RX_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_idx <= bit_nxt;
      shift   <= shift_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt + CW'(1);
    bit_nxt         = bit_idx;
    shift_nxt       = shift;
    push            = 1'b0;
    frame_err_pulse = 1'b0;
    case (state)
      RX_IDLE: begin
        cnt_nxt = '0;
        bit_nxt = '0;
        if (!rx_sync) state_nxt = RX_START;
      end
      RX_START: begin
        // Re-check the line mid start bit so short glitches are ignored.
        if (cnt == HALF_M1) begin
          cnt_nxt   = '0;
          state_nxt = rx_sync ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt == FULL_M1) begin
          cnt_nxt   = '0;
          shift_nxt = {rx_sync, shift[7:1]};
          bit_nxt   = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_nxt = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt == FULL_M1) begin
          cnt_nxt = '0;
          if (rx_sync) begin
            push      = 1'b1;
            state_nxt = RX_IDLE;
          end else begin
            frame_err_pulse = 1'b1;
            state_nxt       = RX_BREAK;
          end
        end
      end
      RX_BREAK: begin
        // A line held low (break) must go high before a new start bit is accepted.
        cnt_nxt = '0;
        if (rx_sync) state_nxt = RX_IDLE;
      end
      default: state_nxt = RX_IDLE;
    endcase
  end

  assign busy = (state != RX_IDLE);
  assign data = shift;

endmodule

// File: rtl/krake_port_rx.sv
// Krake port bus receive slave: serial 8N1 receiver feeding a small FIFO read over the bus.
// Latency: ack one clock after the strobe; a received byte is readable the cycle after its stop-bit sample.
// Backpressure: none on the serial side; a full FIFO drops the byte and sets overrun.
// Ports: clk_i, rst_ni (async assert, retimed release); bus stb_i/we_i/adr_i/dat_i -> ack_o/dat_o;
//        rx_i serial input; irq_o (registered rx_avail); ch_out/ch_oe debug channel.
module krake_port_rx
  import krake_port_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  output logic       ack_o,
  input  logic [7:0] dat_i,
  input  logic [3:0] adr_i,
  output logic [7:0] dat_o,
  input  logic       stb_i,
  input  logic       we_i,
  input  logic       rx_i,
  output logic       irq_o,
  output logic [5:0] ch_out,
  output logic [5:0] ch_oe
);

  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PW + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  // Reset asserts asynchronously but releases two clocks later, synchronous to clk_i.
  logic [1:0] rst_pipe;
  logic       rst_n;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rst_pipe <= '0;
    else         rst_pipe <= {rst_pipe[0], 1'b1};
  end
  assign rst_n = rst_pipe[1];

  logic       rx_sync, rx_busy, rx_push, rx_ferr_pulse;
  logic [7:0] rx_data;

  krake_port_rx_uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk             (clk_i),
    .rst_n           (rst_n),
    .rx              (rx_i),
    .rx_sync         (rx_sync),
    .busy            (rx_busy),
    .push            (rx_push),
    .data            (rx_data),
    .frame_err_pulse (rx_ferr_pulse)
  );

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic [3:0]       count_ext;
  logic             overrun, frame_err;
  logic             rx_avail, full;

  assign rx_avail  = (count != '0);
  assign full      = (count == DEPTH_C);
  assign count_ext = 4'(count);

  // A request is a strobe seen while ack is low, so a held strobe acks every other cycle.
  logic req, is_status, is_data, pop, wr_status, flush, clr_ovr, clr_ferr, push_ok, drop;

  assign req       = stb_i & ~ack_o;
  assign is_status = (adr_i == UART_STATUS);
  assign is_data   = (adr_i == UART_DATAREG);
  assign pop       = req & ~we_i & is_data & rx_avail;
  assign wr_status = req & we_i & is_status;
  assign flush     = wr_status & dat_i[RXST_FLUSH];
  assign clr_ovr   = wr_status & dat_i[RXST_OVR];
  assign clr_ferr  = wr_status & dat_i[RXST_FERR];
  // A full FIFO still accepts a byte when a slot is freed (pop) or emptied (flush) on the same edge.
  assign push_ok   = rx_push & (~full | pop | flush);
  assign drop      = rx_push & ~push_ok;

  logic [7:0] status, rd_mux;

  always_comb begin
    status             = '0;
    status[RXST_AVAIL] = rx_avail;
    status[RXST_FULL]  = full;
    status[RXST_OVR]   = overrun;
    status[RXST_FERR]  = frame_err;
    status[6:4]        = count_ext[2:0];
    status[RXST_BUSY]  = rx_busy;
  end

  // Zero unless a read is being acked, which also keeps dat_o at 0 while ack_o is low.
  always_comb begin
    rd_mux = '0;
    if (req && !we_i) begin
      if (is_status)                rd_mux = status;
      else if (is_data && rx_avail) rd_mux = mem[rd_ptr];
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wr_ptr] <= rx_data;
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      ack_o     <= 1'b0;
      dat_o     <= '0;
      irq_o     <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
    end else begin
      ack_o     <= req;
      dat_o     <= rd_mux;
      irq_o     <= rx_avail;
      // Set events win over a coincident clear.
      overrun   <= drop | (overrun & ~clr_ovr);
      frame_err <= rx_ferr_pulse | (frame_err & ~clr_ferr);
      if (flush) begin
        // Empty the FIFO by catching rd_ptr up; a coincident byte becomes the sole entry.
        rd_ptr <= wr_ptr;
        if (push_ok) begin
          wr_ptr <= wr_ptr + PW'(1);
          count  <= CNT_W'(1);
        end else begin
          count  <= '0;
        end
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + PW'(1);
        if (pop)     rd_ptr <= rd_ptr + PW'(1);
        case ({push_ok, pop})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

  assign ch_out = {ack_o, stb_i, rx_sync, rx_busy, rx_push, frame_err};
  assign ch_oe  = 6'b111111;

  logic unused_bits;
  assign unused_bits = ^{dat_i[7:5], dat_i[1:0], count_ext[3]};

endmodule

// File: tb/tb_krake_port_rx.sv
// Scoreboard bench for krake_port_rx at 16 clocks per bit and a 4-entry FIFO.
module tb_krake_port_rx;

  localparam int CPB = 16;

  logic       clk_i  = 1'b0;
  logic       rst_ni = 1'b0;
  logic       stb_i  = 1'b0;
  logic       we_i   = 1'b0;
  logic       rx_i   = 1'b1;
  logic [7:0] dat_i  = '0;
  logic [3:0] adr_i  = '0;
  logic       ack_o, irq_o;
  logic [7:0] dat_o;
  logic [5:0] ch_out, ch_oe;

  krake_port_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .ack_o(ack_o), .dat_i(dat_i), .adr_i(adr_i),
    .dat_o(dat_o), .stb_i(stb_i), .we_i(we_i), .rx_i(rx_i), .irq_o(irq_o),
    .ch_out(ch_out), .ch_oe(ch_oe)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  // Scoreboard: bit 8 says whether dat_o is checked for that ack.
  logic [8:0] exp_q[$];
  string      name_q[$];

  // Event counters from the debug channel.
  int   push_cnt  = 0;
  int   busy_rise = 0;
  logic busy_d    = 1'b0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h", nm, act, exp);
    end
  endtask

  always @(negedge clk_i) begin : monitor
    logic [8:0] e;
    string      nm;
    if (rst_ni && ack_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_ack: got ack with dat_o=0x%02h, expected no ack", dat_o);
      end else begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        if (e[8]) chk(nm, dat_o, e[7:0]);
      end
    end
  end

  always @(negedge clk_i) begin
    if (ch_out[1]) push_cnt++;
    if (ch_out[2] && !busy_d) busy_rise++;
    busy_d = ch_out[2];
  end

  task automatic bus(input logic w, input logic [3:0] a, input logic [7:0] d,
                     input logic [7:0] e, input logic check, input string nm);
    logic got;
    @(negedge clk_i);
    exp_q.push_back({check, e});
    name_q.push_back(nm);
    stb_i = 1'b1; we_i = w; adr_i = a; dat_i = d;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk_i);
      #1;
      got = ack_o;
    end
    stb_i = 1'b0; we_i = 1'b0;
    if (!got) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: ack=0 after 8 cycles, expected ack=1", nm);
      void'(exp_q.pop_back());
      void'(name_q.pop_back());
    end
    @(negedge clk_i);
  endtask

  task automatic rd(input logic [3:0] a, input logic [7:0] e, input string nm);
    bus(1'b0, a, 8'h00, e, 1'b1, nm);
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d, input string nm);
    bus(1'b1, a, d, 8'h00, 1'b0, nm);
  endtask

  // One 8N1 frame; the stop level is selectable and can be stretched low to form a break.
  task automatic send_byte(input logic [7:0] b, input logic stop, input int extra_low);
    @(negedge clk_i);
    rx_i = 1'b0;
    repeat (CPB) @(negedge clk_i);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      repeat (CPB) @(negedge clk_i);
    end
    rx_i = stop;
    repeat (CPB + extra_low) @(negedge clk_i);
    rx_i = 1'b1;
    repeat (4) @(negedge clk_i);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state.
    repeat (5) @(negedge clk_i);
    chk("reset_ack", {7'b0, ack_o}, 8'h00);
    chk("reset_dat", dat_o, 8'h00);
    chk("reset_irq", {7'b0, irq_o}, 8'h00);
    chk("ch_oe", {2'b0, ch_oe}, 8'h3F);
    rst_ni = 1'b1;
    repeat (4) @(negedge clk_i);
    rd(UART_ST(), 8'h00, "reset_status");

    // Single byte: busy=0, count=1, avail=1.
    send_byte(8'hA5, 1'b1, 0);
    repeat (2) @(negedge clk_i);
    chk("irq_after_byte", {7'b0, irq_o}, 8'h01);
    rd(4'h0, 8'h11, "status_one");
    rd(4'h1, 8'hA5, "data_a5");
    rd(4'h0, 8'h00, "status_empty");

    // Five bytes into a four-entry FIFO: count=4, overrun, full, avail -> 0x47.
    send_byte(8'h01, 1'b1, 0);
    send_byte(8'h02, 1'b1, 0);
    send_byte(8'h03, 1'b1, 0);
    send_byte(8'h04, 1'b1, 0);
    send_byte(8'h55, 1'b1, 0);
    rd(4'h0, 8'h47, "status_overrun");
    rd(4'h1, 8'h01, "data_01");
    rd(4'h1, 8'h02, "data_02");
    rd(4'h1, 8'h03, "data_03");
    rd(4'h1, 8'h04, "data_04");
    rd(4'h1, 8'h00, "data_empty");
    rd(4'h0, 8'h04, "status_ovr_only");
    wr(4'h0, 8'h04, "clr_ovr");
    rd(4'h0, 8'h00, "status_ovr_clr");
    rd(4'h5, 8'h00, "unmapped_read");

    // Framing error followed by a 40-clock break: one reception, no retrigger.
    push_cnt = 0; busy_rise = 0;
    send_byte(8'h3C, 1'b0, 40);
    repeat (4) @(negedge clk_i);
    chk("ferr_busy_rises", 8'(busy_rise), 8'd1);
    chk("ferr_no_push", 8'(push_cnt), 8'd0);
    rd(4'h0, 8'h08, "status_ferr");
    wr(4'h0, 8'h08, "clr_ferr");
    rd(4'h0, 8'h00, "status_ferr_clr");

    // Short glitch shorter than half a bit.
    push_cnt = 0; busy_rise = 0;
    @(negedge clk_i);
    rx_i = 1'b0;
    repeat (5) @(negedge clk_i);
    rx_i = 1'b1;
    repeat (30) @(negedge clk_i);
    chk("glitch_busy_rises", 8'(busy_rise), 8'd1);
    chk("glitch_no_push", 8'(push_cnt), 8'd0);
    chk("glitch_idle", {7'b0, ch_out[2]}, 8'h00);
    rd(4'h0, 8'h00, "status_glitch");

    // Held strobe on DATAREG with two bytes queued.
    send_byte(8'h11, 1'b1, 0);
    send_byte(8'h22, 1'b1, 0);
    @(negedge clk_i);
    exp_q.push_back({1'b1, 8'h11}); name_q.push_back("hold_d0");
    exp_q.push_back({1'b1, 8'h22}); name_q.push_back("hold_d1");
    exp_q.push_back({1'b1, 8'h00}); name_q.push_back("hold_d2");
    stb_i = 1'b1; we_i = 1'b0; adr_i = 4'h1;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk_i);
      #1;
      chk($sformatf("hold_ack%0d", k), {7'b0, ack_o}, (k % 2 == 1) ? 8'h01 : 8'h00);
    end
    stb_i = 1'b0;
    repeat (2) @(negedge clk_i);

    // Reset in the middle of a frame, with one byte pending so irq_o is high.
    send_byte(8'h42, 1'b1, 0);
    repeat (2) @(negedge clk_i);
    chk("irq_before_reset", {7'b0, irq_o}, 8'h01);
    fork
      send_byte(8'h99, 1'b1, 0);
    join_none
    repeat (60) @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    chk("midreset_ack", {7'b0, ack_o}, 8'h00);
    chk("midreset_dat", dat_o, 8'h00);
    chk("midreset_irq", {7'b0, irq_o}, 8'h00);
    chk("midreset_busy", {7'b0, ch_out[2]}, 8'h00);
    wait fork;
    rst_ni = 1'b1;
    repeat (4) @(negedge clk_i);
    rd(4'h0, 8'h00, "status_after_reset");
    send_byte(8'h7E, 1'b1, 0);
    rd(4'h1, 8'h7E, "data_7e");

    repeat (4) @(negedge clk_i);
    chk("scoreboard_drained", 8'(exp_q.size()), 8'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  function automatic logic [3:0] UART_ST();
    return 4'h0;
  endfunction

endmodule
